// File: rtl/f_npc_pcreg_if.sv
// Next-PC bundle: D-stage redirect sources in, fetch PC, fetch fault and pending status out.
interface f_npc_pcreg_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic [ADDR_W-1:0] D_pc;
    logic [25:0]       D_imm26;
    logic [ADDR_W-1:0] FW_D_rs;
    logic              branch;
    logic              D_branch_link;
    logic              jump;
    logic              jr;
    logic              cmp_result;
    logic              Req;
    logic              D_eret;
    logic [ADDR_W-1:0] EPC;
    logic [ADDR_W-1:0] F_pc;
    logic              F_adel;
    logic              npc_pending;

    modport master (
        output stall, D_pc, D_imm26, FW_D_rs, branch, D_branch_link, jump, jr,
               cmp_result, Req, D_eret, EPC,
        input  F_pc, F_adel, npc_pending
    );

    modport slave (
        input  stall, D_pc, D_imm26, FW_D_rs, branch, D_branch_link, jump, jr,
               cmp_result, Req, D_eret, EPC,
        output F_pc, F_adel, npc_pending
    );
endinterface

// File: rtl/f_npc_pcreg.sv
// Fetch PC register with prioritised next-PC select and a stall-tolerant pending-redirect FSM.
// Optional macro NPC_ADEL_EN enables the fetch address-fault window check on F_adel.
module f_npc_pcreg #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE    = 32'h0000_4000,
    parameter bit          ERET_ADD4  = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    f_npc_pcreg_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] LOW28    = ADDR_W'(28'hFFF_FFFF);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_EXC   = ADDR_W'(HANDLER_PC);

    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0] pc,
        input logic [15:0]       off
    );
        return pc + PC_STEP + {{(ADDR_W-18){off[15]}}, off, 2'b00};
    endfunction

    // Upper PC bits are kept above bit 27; masking works even when ADDR_W is exactly 28.
    function automatic logic [ADDR_W-1:0] jump_target(
        input logic [ADDR_W-1:0] pc,
        input logic [25:0]       idx
    );
        return (pc & ~LOW28) | ADDR_W'({idx, 2'b00});
    endfunction

    state_t            state_r;
    logic [ADDR_W-1:0] f_pc_r;
    logic [ADDR_W-1:0] pend_tgt_r;
    logic              pending_r;
    logic              redir_v_s;
    logic [ADDR_W-1:0] tgt_s;

    // Redirect select among D-stage sources; Req is handled in the register block.
    always_comb begin
        redir_v_s = 1'b0;
        tgt_s     = {ADDR_W{1'b0}};
        if (bus.D_eret) begin
            redir_v_s = 1'b1;
            tgt_s     = ERET_ADD4 ? (bus.EPC + PC_STEP) : bus.EPC;
        end else if (bus.branch && bus.cmp_result) begin
            redir_v_s = 1'b1;
            tgt_s     = branch_target(bus.D_pc, bus.D_imm26[15:0]);
        end else if (bus.jump) begin
            redir_v_s = 1'b1;
            tgt_s     = jump_target(bus.D_pc, bus.D_imm26);
        end else if (bus.jr) begin
            redir_v_s = 1'b1;
            tgt_s     = bus.FW_D_rs;
        end else if (bus.D_branch_link && bus.cmp_result) begin
            redir_v_s = 1'b1;
            tgt_s     = branch_target(bus.D_pc, bus.D_imm26[15:0]);
        end else begin
            redir_v_s = 1'b0;
            tgt_s     = {ADDR_W{1'b0}};
        end
    end

    // PC register and pending-redirect FSM; the first redirect seen during a stall wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_r     <= PC_RESET;
            state_r    <= IDLE;
            pend_tgt_r <= {ADDR_W{1'b0}};
            pending_r  <= 1'b0;
        end else if (bus.Req) begin
            f_pc_r    <= PC_EXC;
            state_r   <= IDLE;
            pending_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.stall) begin
                        if (redir_v_s) begin
                            pend_tgt_r <= tgt_s;
                            state_r    <= PENDING;
                            pending_r  <= 1'b1;
                        end
                    end else begin
                        f_pc_r <= redir_v_s ? tgt_s : (f_pc_r + PC_STEP);
                    end
                end
                PENDING: begin
                    if (!bus.stall) begin
                        f_pc_r    <= pend_tgt_r;
                        state_r   <= IDLE;
                        pending_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.F_pc        = f_pc_r;
    assign bus.npc_pending = pending_r;

`ifdef NPC_ADEL_EN
    // One extra bit keeps IM_BASE+IM_SIZE from wrapping at the top of the address space.
    localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(IM_BASE);
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(IM_SIZE);

    assign bus.F_adel = (f_pc_r[1:0] != 2'b00)
                     || ({1'b0, f_pc_r} <  WIN_LO)
                     || ({1'b0, f_pc_r} >= WIN_HI);
`else
    assign bus.F_adel = 1'b0;
`endif

endmodule

// File: tb/tb_f_npc_pcreg.sv
// Directed scoreboard bench for f_npc_pcreg; a second instance runs with ERET_ADD4=0.
module tb_f_npc_pcreg;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pend;
        logic [31:0] pc0;
    } exp_t;

    exp_t sb_q[$];

    f_npc_pcreg_if #(.ADDR_W(32)) bus ();
    f_npc_pcreg_if #(.ADDR_W(32)) bus0 ();

    f_npc_pcreg #(.ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    f_npc_pcreg #(.ADDR_W(32), .ERET_ADD4(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    assign bus0.stall         = bus.stall;
    assign bus0.D_pc          = bus.D_pc;
    assign bus0.D_imm26       = bus.D_imm26;
    assign bus0.FW_D_rs       = bus.FW_D_rs;
    assign bus0.branch        = bus.branch;
    assign bus0.D_branch_link = bus.D_branch_link;
    assign bus0.jump          = bus.jump;
    assign bus0.jr            = bus.jr;
    assign bus0.cmp_result    = bus.cmp_result;
    assign bus0.Req           = bus.Req;
    assign bus0.D_eret        = bus.D_eret;
    assign bus0.EPC           = bus.EPC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_adel(input logic [31:0] pc);
`ifdef NPC_ADEL_EN
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc >= 32'h0000_7000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.stall = 1'b0; bus.D_pc = 32'h0; bus.D_imm26 = 26'h0; bus.FW_D_rs = 32'h0;
        bus.branch = 1'b0; bus.D_branch_link = 1'b0; bus.jump = 1'b0; bus.jr = 1'b0;
        bus.cmp_result = 1'b0; bus.Req = 1'b0; bus.D_eret = 1'b0; bus.EPC = 32'h0;
    endtask

    // Push the expectation for the coming edge, clock, then compare both instances.
    task automatic step(input string tag, input logic [31:0] pc, input logic pend, input logic [31:0] pc0);
        exp_t e;
        sb_q.push_back('{tag, pc, pend, pc0});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk_val({e.tag, ".pc"},    bus.F_pc,                  e.pc);
        chk_val({e.tag, ".pend"},  32'(bus.npc_pending),      32'(e.pend));
        chk_val({e.tag, ".adel"},  32'(bus.F_adel),           32'(exp_adel(e.pc)));
        chk_val({e.tag, ".pc0"},   bus0.F_pc,                 e.pc0);
        chk_val({e.tag, ".pend0"}, 32'(bus0.npc_pending),     32'(e.pend));
        chk_val({e.tag, ".adel0"}, 32'(bus0.F_adel),          32'(exp_adel(e.pc0)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_in();
        reset = 1'b1;
        step("rst0", 32'h3000, 1'b0, 32'h3000);
        step("rst1", 32'h3000, 1'b0, 32'h3000);
        reset = 1'b0;
        step("seq0", 32'h3004, 1'b0, 32'h3004);
        step("seq1", 32'h3008, 1'b0, 32'h3008);

        bus.branch = 1'b1; bus.cmp_result = 1'b1; bus.D_pc = 32'h3004; bus.D_imm26 = 26'h0003;
        step("br_fwd", 32'h3014, 1'b0, 32'h3014);
        bus.D_imm26 = 26'h0FFFF;
        step("br_back", 32'h3004, 1'b0, 32'h3004);
        clear_in();

        bus.stall = 1'b1; bus.jump = 1'b1; bus.D_pc = 32'h3000; bus.D_imm26 = 26'h0000C10;
        step("stl_j", 32'h3004, 1'b1, 32'h3004);
        bus.jump = 1'b0;
        step("stl_h1", 32'h3004, 1'b1, 32'h3004);
        bus.branch = 1'b1; bus.cmp_result = 1'b1; bus.D_pc = 32'h3004; bus.D_imm26 = 26'h0003;
        step("stl_ign", 32'h3004, 1'b1, 32'h3004);
        clear_in();
        step("stl_rel", 32'h3040, 1'b0, 32'h3040);
        step("seq2", 32'h3044, 1'b0, 32'h3044);

        bus.stall = 1'b1; bus.jump = 1'b1; bus.D_pc = 32'h3000; bus.D_imm26 = 26'h0000C10;
        step("pend2", 32'h3044, 1'b1, 32'h3044);
        bus.jump = 1'b0; bus.Req = 1'b1;
        step("req_stl", 32'h4180, 1'b0, 32'h4180);
        clear_in();
        step("req_drop", 32'h4184, 1'b0, 32'h4184);
        bus.Req = 1'b1; bus.D_eret = 1'b1; bus.EPC = 32'h3010;
        step("req_eret", 32'h4180, 1'b0, 32'h4180);
        bus.Req = 1'b0;
        step("eret", 32'h3014, 1'b0, 32'h3010);
        clear_in();
        step("eret_seq", 32'h3018, 1'b0, 32'h3014);

        bus.jr = 1'b1; bus.FW_D_rs = 32'h3002;
        step("jr_mis", 32'h3002, 1'b0, 32'h3002);
        bus.FW_D_rs = 32'h7000;
        step("jr_hi", 32'h7000, 1'b0, 32'h7000);
        bus.FW_D_rs = 32'h6FFC;
        step("jr_top", 32'h6FFC, 1'b0, 32'h6FFC);
        bus.FW_D_rs = 32'h2FFC;
        step("jr_lo", 32'h2FFC, 1'b0, 32'h2FFC);
        bus.FW_D_rs = 32'hFFFF_FFFC;
        step("jr_max", 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
        clear_in();
        step("wrap", 32'h0000_0000, 1'b0, 32'h0000_0000);

        bus.D_branch_link = 1'b1; bus.cmp_result = 1'b1; bus.D_pc = 32'h3100; bus.D_imm26 = 26'h0010;
        step("bal", 32'h3144, 1'b0, 32'h3144);
        bus.jump = 1'b1; bus.D_imm26 = 26'h0000C20;
        step("j_ovr_bal", 32'h3080, 1'b0, 32'h3080);
        clear_in();

        bus.stall = 1'b1; bus.jr = 1'b1; bus.FW_D_rs = 32'h3200;
        step("pend3", 32'h3080, 1'b1, 32'h3080);
        reset = 1'b1; bus.Req = 1'b1; bus.jr = 1'b0;
        step("rst_ovr", 32'h3000, 1'b0, 32'h3000);
        reset = 1'b0;
        clear_in();
        step("rst_seq", 32'h3004, 1'b0, 32'h3004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
